// File: rtl/router_fsm.sv
// Packet-sequencing FSM for the 1xN router input path.
// Ports: clock/resetn; pkt_valid, data_in, parity_done, low_pkt_valid,
//   fifo_full, fifo_empty, soft_reset in; busy and state strobes out.
module router_fsm #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] data_in,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  input  logic                  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  output logic                  busy,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_addr_ok;
  logic                  w_empty_in;
  logic                  w_empty_q;
  logic                  w_srst_q;

  // Port selects by compare so out-of-range addresses never index.
  always_comb begin
    w_addr_ok  = 1'b0;
    w_empty_in = 1'b0;
    w_empty_q  = 1'b0;
    w_srst_q   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_in == i[ADDR_WIDTH-1:0]) begin
        w_addr_ok  = 1'b1;
        w_empty_in = fifo_empty[i];
      end
      if (r_addr == i[ADDR_WIDTH-1:0]) begin
        w_empty_q = fifo_empty[i];
        w_srst_q  = soft_reset[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && pkt_valid && w_addr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = DECODE_ADDRESS;
    case (r_state)
      DECODE_ADDRESS: begin
        if (pkt_valid && w_addr_ok)
          w_next = w_empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        else
          w_next = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY:
        w_next = w_empty_q ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:
        w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
        else                 w_next = LOAD_DATA;
      end
      FIFO_FULL_STATE:
        w_next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      end
      LOAD_PARITY:
        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        w_next = DECODE_ADDRESS;
    endcase
    // Read-timeout on the addressed FIFO aborts the packet.
    if (r_state != DECODE_ADDRESS && w_srst_q)
      w_next = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    busy          = !(r_state == DECODE_ADDRESS ||
                      r_state == LOAD_DATA);
    write_enb_reg = (r_state == LOAD_DATA) ||
                    (r_state == LOAD_AFTER_FULL) ||
                    (r_state == LOAD_PARITY);
  end

endmodule
